multirate_freq_divider: RTL and testbench

- Parametrised successor to the fixed 0.1/1/10/100 Hz divider counter.
- Generates a cascade of decade-spaced rates from one system clock:
  - per-stage one-cycle tick enables;
  - per-stage 50%-duty square waves;
  - a runtime-selectable output with glitch-free switching;
  - a 4-bit decade count of the selected rate.
- Sits between the board clock and display/timer logic that needs slow strobes.

---
 rtl/freqdiv_pkg.sv | 24 ++
 rtl/decade_stage.sv | 36 +++
 rtl/multirate_freq_divider.sv | 110 +++++++++++
 tb/tb_multirate_freq_divider.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/freqdiv_pkg.sv
// Shared constants and elaboration helpers for the multirate frequency divider.
//   DECADE / HALF_DECADE_M1 / DECADE_M1 : decade counter terminal values
//   clog2()       : ceiling log2, used for counter and select widths
//   prescale_ok() : legality check for the stage-0 prescale ratio
package freqdiv_pkg;

  localparam int unsigned DECADE         = 10;
  localparam int unsigned HALF_DECADE_M1 = 4;
  localparam int unsigned DECADE_M1      = 9;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

  // The stage-0 square wave toggles at the half and full count, so the
  // prescale ratio must split into two equal halves.
  function automatic bit prescale_ok(input int unsigned prescale);
    return (prescale >= 2) && ((prescale % 2) == 0);
  endfunction

endpackage

// File: rtl/decade_stage.sv
// One divide-by-ten stage of the rate cascade.
//   clk      in  system clock, rising edge
//   reset    in  synchronous active-low reset
//   tick_in  in  one-cycle strobe of the next faster stage (already en-gated)
//   tick_out out one-cycle strobe every tenth tick_in, phase-aligned with it
//   sq       out 50% square wave at this stage's rate, low after reset
//   count    out decade position 0..9
module decade_stage
  import freqdiv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  output logic       tick_out,
  output logic       sq,
  output logic [3:0] count
);

  logic at_last;
  logic at_half;

  assign at_last  = (count == 4'(DECADE_M1));
  assign at_half  = (count == 4'(HALF_DECADE_M1));
  assign tick_out = tick_in && at_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      sq    <= 1'b0;
    end else if (tick_in) begin
      count <= at_last ? '0 : count + 4'd1;
      if (at_half || at_last) sq <= ~sq;
    end
  end

endmodule

// File: rtl/multirate_freq_divider.sv
// Decade-spaced rate cascade from one system clock with a glitch-free
// runtime-selectable output and a decade count of the selected rate.
//   clk        in  system clock, rising edge
//   reset      in  synchronous active-low reset
//   en         in  count enable; low freezes all state and masks ticks
//   sel        in  requested output stage (values >= NUM_STAGES ignored)
//   tick       out per-stage one-cycle strobes, stage k at BASE_HZ/10^k
//   sq         out per-stage 50% square waves
//   out_tick   out tick[active_sel]
//   out_sq     out sq[active_sel]
//   active_sel out currently applied selection
//   q          out decade count 0..9 of out_tick
module multirate_freq_divider
  import freqdiv_pkg::*;
#(
  parameter  int unsigned CLK_HZ     = 50_000_000,
  parameter  int unsigned BASE_HZ    = 100,
  parameter  int unsigned NUM_STAGES = 4,
  parameter  int unsigned INIT_SEL   = 0,
  localparam int unsigned SEL_W      = (clog2(NUM_STAGES) > 1) ? clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  output logic [NUM_STAGES-1:0] tick,
  output logic [NUM_STAGES-1:0] sq,
  output logic                  out_tick,
  output logic                  out_sq,
  output logic [SEL_W-1:0]      active_sel,
  output logic [3:0]            q
);

  localparam int unsigned PRESCALE = CLK_HZ / BASE_HZ;
  localparam int unsigned C0_W     = (clog2(PRESCALE) > 1) ? clog2(PRESCALE) : 1;
  localparam logic [C0_W-1:0] C0_LAST = C0_W'(PRESCALE - 1);
  localparam logic [C0_W-1:0] C0_HALF = C0_W'(PRESCALE / 2 - 1);

  if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
    $error("multirate_freq_divider: CLK_HZ/BASE_HZ must be even and >= 2");
  end
  if (NUM_STAGES < 1 || INIT_SEL >= NUM_STAGES) begin : g_bad_sel
    $error("multirate_freq_divider: need NUM_STAGES >= 1 and INIT_SEL < NUM_STAGES");
  end

  logic [C0_W-1:0]       c0;
  logic                  sq0;
  logic [NUM_STAGES-1:0] tick_w;
  logic [NUM_STAGES-1:0] sq_w;

  // Stage 0 prescaler.
  always_ff @(posedge clk) begin
    if (!reset) begin
      c0  <= '0;
      sq0 <= 1'b0;
    end else if (en) begin
      c0 <= (c0 == C0_LAST) ? '0 : c0 + C0_W'(1);
      if (c0 == C0_HALF || c0 == C0_LAST) sq0 <= ~sq0;
    end
  end

  assign tick_w[0] = en && (c0 == C0_LAST);
  assign sq_w[0]   = sq0;

  // Per-stage decade positions are not needed at the top; kept visible
  // for debug probing.
  logic [3:0] dk_unused [NUM_STAGES];
  assign dk_unused[0] = '0;

  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
    decade_stage u_stage (
      .clk      (clk),
      .reset    (reset),
      .tick_in  (tick_w[k-1]),
      .tick_out (tick_w[k]),
      .sq       (sq_w[k]),
      .count    (dk_unused[k])
    );
  end

  assign tick = tick_w;
  assign sq   = sq_w;

  // Switching only on tick[max(sel,active_sel)] means every faster stage
  // ticks on the same edge, so both old and new square waves restart low
  // together: no runt pulse, no lost or duplicated tick.
  logic             sel_valid;
  logic [SEL_W-1:0] hi_sel;
  logic             do_switch;

  always_comb begin
    sel_valid = (32'(sel) < NUM_STAGES);
    hi_sel    = (sel > active_sel) ? sel : active_sel;
    do_switch = sel_valid && (sel != active_sel) && tick_w[hi_sel];
  end

  assign out_tick = tick_w[active_sel];
  assign out_sq   = sq_w[active_sel];

  always_ff @(posedge clk) begin
    if (!reset) begin
      active_sel <= SEL_W'(INIT_SEL);
      q          <= '0;
    end else begin
      if (out_tick) q <= (q == 4'(DECADE - 1)) ? '0 : q + 4'd1;
      if (do_switch) active_sel <= sel;
    end
  end

endmodule

// File: tb/tb_multirate_freq_divider.sv
// Scoreboard bench: the stimulus process predicts every cycle's outputs
// from elapsed enabled-edge counts and queues them; a monitor pops and
// compares. Two instances share the stimulus: 4 stages (2-bit sel) and
// 5 stages (3-bit sel, so out-of-range selections can be driven).
module tb_multirate_freq_divider;

  localparam int unsigned P = 10;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b1;
  logic [2:0] sel   = '0;
  logic [1:0] sel_a;

  logic [3:0] tick_a, sq_a, q_a;
  logic       out_tick_a, out_sq_a;
  logic [1:0] asel_a;
  logic [4:0] tick_b, sq_b;
  logic [3:0] q_b;
  logic       out_tick_b, out_sq_b;
  logic [2:0] asel_b;

  assign sel_a = sel[1:0];

  always #5 clk = ~clk;

  multirate_freq_divider #(.CLK_HZ(1000), .BASE_HZ(100), .NUM_STAGES(4), .INIT_SEL(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .sel(sel_a), .tick(tick_a), .sq(sq_a),
    .out_tick(out_tick_a), .out_sq(out_sq_a), .active_sel(asel_a), .q(q_a)
  );

  multirate_freq_divider #(.CLK_HZ(1000), .BASE_HZ(100), .NUM_STAGES(5), .INIT_SEL(0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .sel(sel), .tick(tick_b), .sq(sq_b),
    .out_tick(out_tick_b), .out_sq(out_sq_b), .active_sel(asel_b), .q(q_b)
  );

  typedef struct packed {
    logic [4:0] tick;
    logic [4:0] sq;
    logic       out_tick;
    logic       out_sq;
    logic [2:0] asel;
    logic [3:0] q;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } pair_t;

  pair_t  exp_q[$];
  int     checks = 0;
  int     errors = 0;

  // Reference state: enabled edges since reset, selection and tick count.
  longint n = 0;
  int     act_a = 0, act_b = 0, qa = 0, qb = 0;
  bit     model_ok = 1'b0;

  // Stage k has period P*10^k; after nn enabled edges it ticks when the
  // next edge completes a period, and its square wave has toggled once per
  // elapsed half period.
  function automatic obs_t predict(input int ns, input int act, input int qv,
                                   input bit en_v, input longint nn);
    obs_t   o;
    longint per;
    o   = '0;
    per = P;
    for (int k = 0; k < ns; k++) begin
      o.tick[k] = en_v && ((nn % per) == per - 1);
      o.sq[k]   = ((nn / (per / 2)) % 2) == 1;
      per       = per * 10;
    end
    o.out_tick = o.tick[act];
    o.out_sq   = o.sq[act];
    o.asel     = 3'(act);
    o.q        = 4'(qv);
    return o;
  endfunction

  function automatic int next_act(input int ns, input int act, input int sv, input obs_t o);
    int hi;
    if (sv >= ns || sv == act) return act;
    hi = (sv > act) ? sv : act;
    return o.tick[hi] ? sv : act;
  endfunction

  task automatic step(input bit en_v, input int sel_v, input bit rst_v);
    obs_t ea, eb;
    @(negedge clk);
    en    = en_v;
    sel   = 3'(sel_v);
    reset = rst_v;
    ea = predict(4, act_a, qa, en_v, n);
    eb = predict(5, act_b, qb, en_v, n);
    if (model_ok) exp_q.push_back({ea, eb});
    if (!rst_v) begin
      n = 0; act_a = 0; act_b = 0; qa = 0; qb = 0;
      model_ok = 1'b1;
    end else begin
      if (ea.out_tick) qa = (qa + 1) % 10;
      if (eb.out_tick) qb = (qb + 1) % 10;
      act_a = next_act(4, act_a, sel_v % 4, ea);
      act_b = next_act(5, act_b, sel_v, eb);
      if (en_v) n++;
    end
  endtask

  // Monitor: samples mid-cycle, after inputs settle and before the edge.
  initial begin
    pair_t e, got;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {{1'b0, tick_a}, {1'b0, sq_a}, out_tick_a, out_sq_a, {1'b0, asel_a}, q_a,
               tick_b, sq_b, out_tick_b, out_sq_b, asel_b, q_b};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t actual a=%h b=%h required a=%h b=%h",
                   $time, got.a, got.b, e.a, e.b);
        end
      end
    end
  end

  initial begin
    int cur_sel;

    // Power-up reset, then a long free run through the first stage-3 tick.
    repeat (3) step(1'b1, 0, 1'b0);
    repeat (10050) step(1'b1, 0, 1'b1);

    // Request stage 2 at cycle 300; switch lands on the cycle-1000 edge.
    step(1'b1, 0, 1'b0);
    for (int i = 0; i < 2100; i++) step(1'b1, (i >= 300) ? 2 : 0, 1'b1);

    // Out-of-range request (ignored by the 5-stage instance).
    step(1'b1, 0, 1'b0);
    for (int i = 0; i < 2000; i++) step(1'b1, (i >= 50) ? 5 : 0, 1'b1);

    // Enable low for 37 cycles starting at cycle 3.
    step(1'b1, 0, 1'b0);
    for (int i = 0; i < 200; i++) step(!(i >= 3 && i < 40), 0, 1'b1);

    // Mid-operation reset with c0=6, sq[1]=1, active_sel=2.
    step(1'b1, 0, 1'b0);
    for (int i = 0; i < 1056; i++) step(1'b1, 2, 1'b1);
    step(1'b1, 2, 1'b0);
    for (int i = 0; i < 200; i++) step(1'b1, 0, 1'b1);

    // Random enables, selections (including invalid ones) and rare resets.
    cur_sel = 0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 49) == 0) cur_sel = int'($urandom_range(0, 7));
      step($urandom_range(0, 9) != 0, cur_sel, $urandom_range(0, 2999) != 0);
    end

    @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
